// File: rtl/cache_pkg.sv
// cache_pkg
// Shared definitions for the direct-mapped write-through cache subsystem:
// address field widths, geometry, the cache/memory line type, the
// controller state enum, and the power-up image of main memory.
package cache_pkg;

  localparam int DATA_W         = 32;
  localparam int LINES          = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int MEM_LINES      = 256;
  localparam int TAG_W          = 24;
  localparam int IDX_W          = 4;
  localparam int OFF_W          = 2;
  localparam int MEM_AW         = 8;

  typedef logic [WORDS_PER_LINE-1:0][DATA_W-1:0] line_t;

  typedef enum logic {
    LOOKUP,
    REFILL
  } state_t;

  // Power-up content of main memory: word n (byte address 4n) holds n.
  function automatic logic [DATA_W-1:0] image_word(input logic [MEM_AW-1:0] line_addr,
                                                   input logic [OFF_W-1:0]  word_sel);
    return {{(DATA_W-MEM_AW-OFF_W){1'b0}}, line_addr, word_sel};
  endfunction

  function automatic line_t image_line(input logic [MEM_AW-1:0] line_addr);
    line_t l;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      l[w] = image_word(line_addr, OFF_W'(w));
    end
    return l;
  endfunction

endpackage

// File: rtl/cache_if.sv
// cache_if
// Host-side request/handshake bundle of the cache subsystem.
//   ab    : byte address (bits 1:0 ignored)
//   cmwr  : write enable, only meaningful while rd is high
//   rd    : bus direction, 0 = DUT drives the data bus, 1 = host drives it
//   ready : registered completion flag from the cache
// The bidirectional data bus itself stays a plain inout on the top so that
// both tristate drivers resolve on a single net.
interface cache_if;
  import cache_pkg::*;

  logic [DATA_W-1:0] ab;
  logic              cmwr;
  logic              rd;
  logic              ready;

  modport master (output ab, output cmwr, output rd, input ready);
  modport slave  (input ab, input cmwr, input rd, output ready);

endinterface

// File: rtl/main_mem.sv
// main_mem
// Backing store: 256 lines x 128 bits.
//   clk       : clock
//   line_addr : line address for both the read and the write port
//   rd_line   : combinational read of the whole addressed line
//   we        : synchronous single-word write enable
//   word_sel  : word within the line to write
//   wdata     : write data
// The array stores each word XOR-ed with its power-up image (word n = n).
// Block RAM configures to all zeros, so the required start-up contents
// appear without an initialisation pass or any reset of the array.
module main_mem
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic [MEM_AW-1:0] line_addr,
  output line_t             rd_line,
  input  logic              we,
  input  logic [OFF_W-1:0]  word_sel,
  input  logic [DATA_W-1:0] wdata
);

  line_t store [MEM_LINES];

  assign rd_line = store[line_addr] ^ image_line(line_addr);

  // Single-word write, stored relative to the power-up image.
  always_ff @(posedge clk) begin
    if (we) begin
      store[line_addr][word_sel] <= wdata ^ image_word(line_addr, word_sel);
    end
  end

endmodule

// File: rtl/cache_top.sv
// cache_top
// Direct-mapped (16 lines x 4 words), write-through, no-write-allocate
// cache in front of main_mem.
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : host request bundle (ab, cmwr, rd in; ready out)
//   d     : shared 32-bit data bus, driven from dout while rd is low
// Read hit answers one edge after sampling; a miss spends one edge
// detecting, one refilling the whole line, then hits on the retry.
module cache_top
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  cache_if.slave            bus,
  inout  wire  [DATA_W-1:0] d
);

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic [MEM_AW-1:0] mem_line_addr;
  logic              unused_byte_bits;

  assign tag              = bus.ab[31:8];
  assign idx              = bus.ab[7:4];
  assign off              = bus.ab[3:2];
  assign mem_line_addr    = bus.ab[11:4];
  assign unused_byte_bits = ^bus.ab[1:0];

  logic [TAG_W-1:0] tag_arr [LINES];
  line_t            data_arr [LINES];
  logic [LINES-1:0] valid;

  state_t            state, next_state;
  logic [DATA_W-1:0] dout;
  logic              ready_q;
  logic              ready_d;
  logic              dout_load;
  logic              line_we;
  logic              word_we;
  logic              mem_we;
  logic              hit;
  line_t             mem_line;

  assign hit = valid[idx] && (tag_arr[idx] == tag);

  main_mem u_mem (
    .clk       (clk),
    .line_addr (mem_line_addr),
    .rd_line   (mem_line),
    .we        (mem_we),
    .word_sel  (off),
    .wdata     (d)
  );

  // Controller decode. A write commits in LOOKUP whether or not it hits;
  // the cached copy is patched only on a hit, so no line is allocated.
  always_comb begin
    next_state = state;
    ready_d    = 1'b0;
    dout_load  = 1'b0;
    line_we    = 1'b0;
    word_we    = 1'b0;
    mem_we     = 1'b0;
    case (state)
      LOOKUP: begin
        if (!bus.rd) begin
          if (hit) begin
            dout_load = 1'b1;
            ready_d   = 1'b1;
          end else begin
            next_state = REFILL;
          end
        end else if (bus.cmwr) begin
          mem_we  = 1'b1;
          word_we = hit;
          ready_d = 1'b1;
        end
      end
      REFILL: begin
        line_we    = 1'b1;
        next_state = LOOKUP;
      end
      default: next_state = LOOKUP;
    endcase
  end

  // Control state, valid bits and the output register. Reset drops every
  // valid bit, which also discards a refill that was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOOKUP;
      valid   <= '0;
      dout    <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= next_state;
      ready_q <= ready_d;
      if (dout_load) begin
        dout <= data_arr[idx][off];
      end
      if (line_we) begin
        valid[idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; validity alone decides hits.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_arr[idx] <= mem_line;
      tag_arr[idx]  <= tag;
    end else if (word_we) begin
      data_arr[idx][off] <= d;
    end
  end

  assign bus.ready = ready_q;
  assign d         = bus.rd ? {DATA_W{1'bz}} : dout;

endmodule

// File: tb/tb_cache_top.sv
// tb_cache_top
// Self-checking bench for cache_top: directed scenarios followed by random
// reads, writes and idles, compared against a behavioural model of the
// memory contents and of which line each index currently holds.
module tb_cache_top;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] host_d;
  wire  [31:0] d;
  int          tests = 0;
  int          fails = 0;

  cache_if bus ();

  assign d = bus.rd ? host_d : 32'bz;

  cache_top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .d     (d)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Reference: word-addressed main memory plus, per index, the cached
  // line image, its tag and whether it is present.
  logic [31:0] m_mem   [1024];
  logic [31:0] m_line  [16][4];
  logic [23:0] m_tag   [16];
  bit          m_valid [16];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] v);
    bus.rd   = r;
    bus.cmwr = w;
    bus.ab   = a;
    host_d   = v;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  function automatic bit modelHit(input logic [31:0] a);
    return m_valid[a[7:4]] && (m_tag[a[7:4]] == a[31:8]);
  endfunction

  task automatic doRead(input logic [31:0] a, output logic [31:0] got, output int lat);
    int          exp_lat;
    logic [31:0] exp;
    exp_lat = modelHit(a) ? 1 : 3;
    if (!modelHit(a)) begin
      for (int w = 0; w < 4; w++) m_line[a[7:4]][w] = m_mem[{a[11:4], w[1:0]}];
      m_tag[a[7:4]]   = a[31:8];
      m_valid[a[7:4]] = 1'b1;
    end
    exp = m_line[a[7:4]][a[3:2]];
    applyStimulus(1'b0, 1'($urandom_range(0, 1)), a, $urandom);
    lat = 0;
    do begin
      stepClock();
      lat++;
    end while (!bus.ready && lat < 8);
    checkOutput("read_latency", 32'(lat), 32'(exp_lat));
    checkOutput("read_data", d, exp);
    got = d;
  endtask

  task automatic doWrite(input logic [31:0] a, input logic [31:0] v);
    if (modelHit(a)) m_line[a[7:4]][a[3:2]] = v;
    m_mem[a[11:2]] = v;
    applyStimulus(1'b1, 1'b1, a, v);
    stepClock();
    checkOutput("write_ready", {31'b0, bus.ready}, 32'd1);
    checkOutput("write_bus_released", d, v);
  endtask

  task automatic doIdle(input logic [31:0] a);
    applyStimulus(1'b1, 1'b0, a, $urandom);
    stepClock();
    checkOutput("idle_ready", {31'b0, bus.ready}, 32'd0);
  endtask

  // Hard stop in case the bench itself stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] got;
    int          lat;
    logic [31:0] a;
    logic [19:0] hi;

    for (int n = 0; n < 1024; n++) m_mem[n] = 32'(n);
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    #12;
    checkOutput("reset_ready", {31'b0, bus.ready}, 32'd0);
    checkOutput("reset_dout", d, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    stepClock();

    doRead(32'h0000_0000, got, lat);
    checkOutput("tp_miss0_lat", 32'(lat), 32'd3);
    checkOutput("tp_miss0_data", got, 32'h0);
    doRead(32'h0000_0004, got, lat);
    checkOutput("tp_hit4_lat", 32'(lat), 32'd1);
    checkOutput("tp_hit4_data", got, 32'h1);

    doRead(32'h0000_0010, got, lat);
    checkOutput("tp_read10", got, 32'h4);
    doRead(32'h0000_001C, got, lat);
    checkOutput("tp_hit1c_lat", 32'(lat), 32'd1);
    checkOutput("tp_hit1c_data", got, 32'h7);

    doWrite(32'h0004_0020, 32'h8888_8888);
    doRead(32'h0000_0020, got, lat);
    checkOutput("tp_alias_lat", 32'(lat), 32'd3);
    checkOutput("tp_alias_data", got, 32'h8888_8888);

    doWrite(32'h0000_0030, 32'hCCCC_CCCC);
    doRead(32'h0000_0030, got, lat);
    checkOutput("tp_noalloc_lat", 32'(lat), 32'd3);
    checkOutput("tp_noalloc_data", got, 32'hCCCC_CCCC);
    doRead(32'h0000_0034, got, lat);
    checkOutput("tp_line34_data", got, 32'hD);

    doRead(32'h0000_0000, got, lat);
    doWrite(32'h0000_0000, 32'h1234_5678);
    doRead(32'h0000_0000, got, lat);
    checkOutput("tp_writehit_lat", 32'(lat), 32'd1);
    checkOutput("tp_writehit_data", got, 32'h1234_5678);
    doRead(32'h0000_0100, got, lat);
    checkOutput("tp_replace_lat", 32'(lat), 32'd3);
    checkOutput("tp_replace_data", got, 32'h40);

    doIdle(32'h0000_0100);

    // Reset in the middle of a refill of a line that is not cached.
    applyStimulus(1'b0, 1'b0, 32'h0000_0200, 32'h0);
    stepClock();
    checkOutput("refill_ready_low", {31'b0, bus.ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrefill_reset_ready", {31'b0, bus.ready}, 32'd0);
    checkOutput("midrefill_reset_dout", d, 32'h0);
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    stepClock();
    rst_n = 1'b1;
    doRead(32'h0000_0200, got, lat);
    checkOutput("after_reset_lat", 32'(lat), 32'd3);
    checkOutput("after_reset_data", got, 32'h80);

    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 2))
        0: hi = 20'h00000;
        1: hi = 20'h00040;
        default: hi = 20'hFFFFF;
      endcase
      a = {hi, 2'b00, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom), 2'($urandom)};
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: doRead(a, got, lat);
        5, 6, 7:       doWrite(a, $urandom);
        default:       doIdle(a);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_top.md
# cache_top

Direct-mapped, write-through cache with its own backing main memory, behind a single shared bidirectional 32-bit data bus. The host presents a byte address and a read/write strobe; reads are served from the cache (refilling a whole line from main memory on a miss), writes update main memory and any cached copy. It is the top-level memory subsystem used by the cache exercise.

## Interface
- `LINES`, 16: number of cache lines; index = `AB[7:4]`.
- `WORDS_PER_LINE`, 4: words per line, fixed; word offset = `AB[3:2]`.
- `MEM_LINES`, 256: main-memory depth in lines; memory line address = `AB[11:4]`. Higher address bits alias in memory.
- `CLK` input 1: single clock; all state changes on the rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `AB` input 32: byte address. `AB[1:0]` ignored. Tag = `AB[31:8]`.
- `CMWr` input 1: write enable; effective only when `RD`=1.
- `RD` input 1: bus direction. 0 = read, DUT drives `D`. 1 = host drives `D`, DUT releases it.
- `D` inout 32: data bus. The DUT drives the `DOUT` register when `RD`=0 and is high-Z when `RD`=1.
- `READY` output 1: registered; high for the cycle after a read hit or a write commit.

## Operation
- Reset clears all valid bits, sets state LOOKUP, `DOUT`=0, `READY`=0. Cache data, tags and main memory are not reset.
- Main memory contents at time zero: word n (byte address 4n) holds value n.
- FSM states:
  - LOOKUP (default).
  - REFILL.
- **LOOKUP with `RD`=0 (read)**: compare `valid[idx]` and `tag[idx]`==`AB[31:8]`.
  - Hit: `DOUT` <= selected word, `READY` <= 1, stay in LOOKUP.
  - Miss: `READY` <= 0, go to REFILL.
- **REFILL**: copy the 128-bit memory line `AB[11:4]` into line idx in one cycle. Set the tag and the valid bit, `READY` <= 0, return to LOOKUP. The retried lookup then hits.
- **LOOKUP with `RD`=1, `CMWr`=1 (write)**: write-through, no write-allocate.
  - Memory word (`AB[11:2]`) <= `D`.
  - On a hit, the cached word <= `D` in the same cycle.
  - `READY` <= 1. Valid bits are unchanged on a miss.
- **`RD`=1, `CMWr`=0**: idle. No state change; `READY` <= 0.
- `CMWr` is ignored when `RD`=0.
- Inputs are held stable by the host until `READY`. Repeated writes with the same inputs are idempotent.
- If `AB` changes during REFILL, the refill completes for the address sampled at that edge, and lookup restarts on the new address.

## Timing
- Read hit: address sampled at edge k; `DOUT`/`READY` valid after edge k+1 (1-cycle latency).
- Read miss: edge k detects the miss, edge k+1 refills, edge k+2 hits. Data and `READY` are valid after edge k+2 (3 cycles).
- Write: committed at the sampling edge; `READY` is high the following cycle.
- `D` direction follows `RD` combinationally: no turnaround cycle and no contention when `RD`=1.
- Reset is asynchronous on assertion. Deassertion is taken synchronously by the next edge. Reset during REFILL aborts the refill and leaves the line invalid.

## Structure
- Shared package `cache_pkg`:
  - Field widths: `TAG_W`=24, `IDX_W`=4, `OFF_W`=2.
  - Line type: 4×32 bits.
  - FSM state enum {LOOKUP, REFILL}.
- Sub-module `main_mem`: 256×128-bit array.
  - Combinational line read.
  - Synchronous single-word write with word select.
  - Initialised to word n = n.
- Tag/valid/data arrays and the FSM live in `cache_top`.

## Test plan
- Reset, then read `AB`=0x00000000 with `RD`=0 → miss; `D`=0x00000000 and `READY`=1 within 3 cycles. Re-read `AB`=0x00000004 → hit in 1 cycle, `D`=0x00000001.
- Read `AB`=0x00000010 → miss then `D`=0x00000004. Then read 0x0000001C → hit, `D`=0x00000007.
- Write `AB`=0x00040020, `D`=0x88888888, `CMWr`=1, `RD`=1 → DUT `D` high-Z, `READY` next cycle. Read 0x00000020 → miss, refill, `D`=0x88888888 (memory alias).
- Write `AB`=0x00000030, `D`=0xCCCCCCCC, then read 0x00000030 → `D`=0xCCCCCCCC. Read 0x00000034 from the same line → hit, `D`=0x0000000D.
- Read 0x00000000 (hit), then write 0x00000000 = 0x12345678 while cached, then read → 1-cycle hit, `D`=0x12345678. A subsequent read of 0x00000100 maps to the same index with a different tag → miss, and the line is replaced with `D`=0x00000040.
- Assert `RST_N` mid-REFILL → `READY`=0, `DOUT`=0 immediately. A following read of the same address misses again.
